// File: rtl/fa_pkg.sv
// Shared widths and word types for the 8-bit ripple-carry adder.
package fa_pkg;

  localparam int unsigned FA_W       = 8;
  localparam int unsigned FA_SLICE_W = 4;

  typedef logic [FA_W-1:0]       fa_word_t;
  typedef logic [FA_SLICE_W-1:0] fa_slice_t;

endpackage : fa_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple-carry slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/rca_4.sv
// Combinational 4-bit ripple-carry slice; c3 exposes the carry into the top bit.
module rca_4
  import fa_pkg::*;
(
  input  fa_slice_t a,
  input  fa_slice_t b,
  input  logic      cin,
  output fa_slice_t sum,
  output logic      cout,
  output logic      c3
);

  logic [FA_SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < FA_SLICE_W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[FA_SLICE_W];
  assign c3   = c[FA_SLICE_W-1];

endmodule : rca_4

// File: rtl/fa_rca_8bit.sv
// 8-bit registered ripple-carry adder built from two rca_4 slices.
// Optional signed-overflow output enabled by defining FA_RCA_8_OVF_EN.
module fa_rca_8bit
  import fa_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  fa_word_t a,
  input  fa_word_t b,
  output logic     out_valid,
  output fa_word_t sum,
  output logic     carry
`ifdef FA_RCA_8_OVF_EN
  ,
  output logic     overflow
`endif
);

  fa_word_t sum_comb;
  logic     c4;
  logic     c8;
  logic     c3_lo;
  logic     c7;

  rca_4 u_slice0 (
    .a    (a[FA_SLICE_W-1:0]),
    .b    (b[FA_SLICE_W-1:0]),
    .cin  (1'b0),
    .sum  (sum_comb[FA_SLICE_W-1:0]),
    .cout (c4),
    .c3   (c3_lo)
  );

  rca_4 u_slice1 (
    .a    (a[FA_W-1:FA_SLICE_W]),
    .b    (b[FA_W-1:FA_SLICE_W]),
    .cin  (c4),
    .sum  (sum_comb[FA_W-1:FA_SLICE_W]),
    .cout (c8),
    .c3   (c7)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_comb;
      carry     <= c8;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef FA_RCA_8_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= c8 ^ c7;
    end
  end

  // Carry into bit 3 of the low slice has no consumer.
  logic unused_carries;
  assign unused_carries = c3_lo;
`else
  logic unused_carries;
  assign unused_carries = c3_lo ^ c7;
`endif

endmodule : fa_rca_8bit

// File: tb/tb_fa_rca_8bit.sv
// Scoreboard bench for fa_rca_8bit: directed corner cases followed by random traffic.
module tb_fa_rca_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic [7:0] sum;
  logic       carry;
`ifdef FA_RCA_8_OVF_EN
  logic       overflow;
`endif

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fa_rca_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry)
`ifdef FA_RCA_8_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int unsigned total;
    total   = int'(x) + int'(y);
    e.sum   = total[7:0];
    e.carry = (total >= 256);
    e.ovf   = (x[7] == y[7]) && (e.sum[7] != x[7]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Driver: inputs change 2 time units after an edge, so the next edge samples them.
  task automatic drive(input logic r, input logic v, input logic [7:0] x, input logic [7:0] y);
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    if (v && !r) exp_q.push_back(model(x, y));
    @(posedge clk);
    #2;
  endtask

  // Monitor: samples 1 unit after each edge, while rst/in_valid still show what that edge saw.
  initial begin : monitor
    exp_t held;
    exp_t e;
    logic edge_rst;
    logic edge_valid;
    held = '{sum: 8'h00, carry: 1'b0, ovf: 1'b0};
    forever begin
      @(posedge clk);
      edge_rst   = rst;
      edge_valid = in_valid;
      #1;
      check("out_valid", 32'(out_valid), 32'(edge_valid && !edge_rst));
      if (edge_rst) begin
        held = '{sum: 8'h00, carry: 1'b0, ovf: 1'b0};
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL scoreboard_empty actual=out_valid required=queued_entry at %0t", $time);
        end else begin
          held = exp_q.pop_front();
        end
      end
      e = held;
      check("sum", 32'(sum), 32'(e.sum));
      check("carry", 32'(carry), 32'(e.carry));
`ifdef FA_RCA_8_OVF_EN
      check("overflow", 32'(overflow), 32'(e.ovf));
`endif
    end
  end

  initial begin : stimulus
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    @(posedge clk);
    #2;
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'h00, 8'h01);
    drive(1'b0, 1'b1, 8'h77, 8'h55);
    drive(1'b0, 1'b1, 8'h8C, 8'h74);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    drive(1'b0, 1'b0, 8'h12, 8'h34);
    drive(1'b0, 1'b0, 8'hAB, 8'hCD);
    drive(1'b0, 1'b1, 8'hFF, 8'h01);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'h80, 8'h80);
    drive(1'b0, 1'b1, 8'h7F, 8'h01);
    drive(1'b1, 1'b1, 8'hF0, 8'h0F);
    drive(1'b0, 1'b1, 8'h3C, 8'hC4);
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fa_rca_8bit
